// File: rtl/shift_alu_arbiter.sv
// shift_alu_arbiter
// Shares one registered shift ALU between two requesters. A request is
// accepted over a valid/ready handshake (round-robin on ties), issued to the
// ALU for one cycle, and the registered ALU result is returned on the granted
// requester's response channel. Only one transaction is in flight at a time.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (N = 0, 1)
//   reqN_in/shift/op         operand, shift amount, operation code
//   rspN_valid/ready         response handshake for requester N
//   rsp_data                 result, shared by both response channels
//   alu_enable/in/shift/op   drive to the shared ALU (enable is one cycle wide)
//   alu_out                  registered ALU result, valid one cycle after enable
//   busy                     a transaction is in progress
//   ops_done                 completed transaction count, wraps at 16 bits

`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 32
`endif

module shift_alu_arbiter #(
  parameter int unsigned reg_wd = `REGISTER_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [reg_wd-1:0] req0_in,
  input  logic [4:0]        req0_shift,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [reg_wd-1:0] req1_in,
  input  logic [4:0]        req1_shift,
  input  logic [2:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [reg_wd-1:0] rsp_data,
  output logic              alu_enable,
  output logic [reg_wd-1:0] alu_in,
  output logic [4:0]        alu_shift,
  output logic [2:0]        alu_op,
  input  logic [reg_wd-1:0] alu_out,
  output logic              busy,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic last_grant;
  logic grant_id;
  logic pick;
  logic any_valid;
  logic accept;
  logic rsp_fire;

  // Round-robin pick: on a tie the requester not granted last time wins;
  // otherwise whichever requester is valid.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      pick = ~last_grant;
    end else begin
      pick = req1_valid;
    end
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_enable = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req0_ready = ~pick;
          req1_ready = pick;
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        next_state = RESP;
      end
      RESP: begin
        rsp_fire = grant_id ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
        if (rsp_fire) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      alu_in     <= '0;
      alu_shift  <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      ops_done   <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      if (accept) begin
        grant_id   <= pick;
        last_grant <= pick;
        alu_in     <= pick ? req1_in    : req0_in;
        alu_shift  <= pick ? req1_shift : req0_shift;
        alu_op     <= pick ? req1_op    : req0_op;
      end
      if (state == WAIT) begin
        rsp_data   <= alu_out;
        rsp0_valid <= ~grant_id;
        rsp1_valid <= grant_id;
      end
      if (rsp_fire) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
        ops_done   <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_shift_alu_arbiter.sv
// Testbench for shift_alu_arbiter: a registered ALU stub, a transaction-age
// model checked every cycle, and directed scenarios with literal expectations.

module tb_shift_alu_arbiter;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_in = '0, req1_in = '0;
  logic [4:0]    req0_shift = '0, req1_shift = '0;
  logic [2:0]    req0_op = '0, req1_op = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0]  rsp_data, alu_in, alu_out;
  logic          alu_enable, busy;
  logic [4:0]    alu_shift;
  logic [2:0]    alu_op;
  logic [15:0]   ops_done;

  int compared   = 0;
  int mismatched = 0;
  bit stub_const = 1'b0;
  bit force_ops  = 1'b0;

  always #5 clock = ~clock;

  shift_alu_arbiter #(.reg_wd(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_shift(req0_shift), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_shift(req1_shift), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .alu_enable(alu_enable), .alu_in(alu_in), .alu_shift(alu_shift),
    .alu_op(alu_op), .alu_out(alu_out),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [W-1:0] stub_fn(input logic [W-1:0] a,
                                           input logic [4:0] s,
                                           input logic [2:0] o);
    if (stub_const) return 32'hDEAD_BEEF;
    return (a << s) ^ {29'h0, o} ^ 32'hA5A5_0000;
  endfunction

  // Registered ALU stub sharing the design's reset.
  always @(posedge clock or posedge reset) begin
    if (reset) alu_out <= '0;
    else if (alu_enable) alu_out <= stub_fn(alu_in, alu_shift, alu_op);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is described by its age in cycles since acceptance.
  bit           m_active, m_id, m_last, force_seen;
  int           m_age, win;
  logic [W-1:0] m_in, m_data;
  logic [4:0]   m_sh;
  logic [2:0]   m_op;
  logic [15:0]  m_ops;
  bit           grants[$];

  always @(negedge clock) begin
    if (force_ops && !force_seen) begin
      m_ops = 16'hFFFF;
      force_seen = 1'b1;
    end
    if (reset) begin
      m_active = 0; m_id = 0; m_last = 1; m_age = 0;
      m_in = '0; m_data = '0; m_sh = '0; m_op = '0; m_ops = '0;
    end
    win = -1;
    if (!reset && !m_active) begin
      if (req0_valid && req1_valid) win = m_last ? 0 : 1;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
    end
    check("req0_ready", 32'(req0_ready), 32'(win == 0));
    check("req1_ready", 32'(req1_ready), 32'(win == 1));
    check("busy", 32'(busy), 32'(m_active));
    check("alu_enable", 32'(alu_enable), 32'(m_active && m_age == 1));
    check("rsp0_valid", 32'(rsp0_valid), 32'(m_active && m_age >= 3 && !m_id));
    check("rsp1_valid", 32'(rsp1_valid), 32'(m_active && m_age >= 3 && m_id));
    check("rsp_data", rsp_data, m_data);
    check("alu_in", alu_in, m_in);
    check("alu_shift", 32'(alu_shift), 32'(m_sh));
    check("alu_op", 32'(alu_op), 32'(m_op));
    check("ops_done", 32'(ops_done), 32'(m_ops));
    if (req0_valid && req0_ready) grants.push_back(1'b0);
    if (req1_valid && req1_ready) grants.push_back(1'b1);
    if (!reset) begin
      if (win >= 0) begin
        m_active = 1; m_age = 1; m_id = win[0]; m_last = win[0];
        m_in = (win == 1) ? req1_in : req0_in;
        m_sh = (win == 1) ? req1_shift : req0_shift;
        m_op = (win == 1) ? req1_op : req0_op;
      end else if (m_active) begin
        if (m_age >= 3) begin
          if (m_id ? rsp1_ready : rsp0_ready) begin
            m_active = 0;
            m_ops = m_ops + 16'd1;
          end
        end else begin
          m_age++;
          if (m_age == 3) m_data = stub_fn(m_in, m_sh, m_op);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for requester n's handshake, then moves into the following cycle.
  task automatic wait_accept(input int n);
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      seen = (n == 1) ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL accept_timeout: req%0d got no ready, expected ready within 30 cycles", n);
    end
    tick();
  endtask

  // Waits (at a falling edge) until requester n's response is valid.
  task automatic wait_rsp(input int n);
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      seen = (n == 1) ? rsp1_valid : rsp0_valid;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL rsp_timeout: rsp%0d_valid low, expected high within 30 cycles", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_alu_in", alu_in, 32'd0);
    #1 reset = 1'b0;
    tick();

    // Single request from requester 0, stub returns a constant
    stub_const = 1'b1;
    req0_in = 32'h0000_00F0; req0_shift = 5'd4; req0_op = 3'b000;
    req0_valid = 1'b1;
    @(negedge clock);
    check("t1_req0_ready_A", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clock);
    check("t1_enable_A1", 32'(alu_enable), 32'd1);
    check("t1_alu_in_A1", alu_in, 32'h0000_00F0);
    check("t1_alu_shift_A1", 32'(alu_shift), 32'd4);
    tick();
    @(negedge clock);
    check("t1_enable_A2", 32'(alu_enable), 32'd0);
    check("t1_rsp0_A2", 32'(rsp0_valid), 32'd0);
    tick();
    @(negedge clock);
    check("t1_rsp0_A3", 32'(rsp0_valid), 32'd1);
    check("t1_data_A3", rsp_data, 32'hDEAD_BEEF);
    tick();
    @(negedge clock);
    check("t1_ops_A4", 32'(ops_done), 32'd1);
    check("t1_busy_A4", 32'(busy), 32'd0);
    stub_const = 1'b0;

    // Both requesters continuously valid for four transactions
    do_reset();
    req0_in = 32'h0000_0011; req0_shift = 5'd1; req0_op = 3'd2;
    req1_in = 32'h0000_2200; req1_shift = 5'd3; req1_op = 3'd5;
    grants.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (16) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("t3_ops_done", 32'(ops_done), 32'd4);
    check("t3_grant_count", 32'(grants.size()), 32'd4);
    for (int unsigned i = 0; i < 4 && i < grants.size(); i++)
      check("t3_grant_order", 32'(grants[i]), 32'(i % 2));
    tick();

    // Back-pressure on requester 1 while requester 0 waits
    req1_in = 32'h0000_0F0F; req1_shift = 5'd8; req1_op = 3'd1;
    rsp1_ready = 1'b0; req1_valid = 1'b1;
    wait_accept(1);
    req1_valid = 1'b0;
    req0_in = 32'h0000_AAAA; req0_shift = 5'd2; req0_op = 3'd6;
    req0_valid = 1'b1;
    wait_rsp(1);
    for (int k = 0; k < 5; k++) begin
      check("t4_rsp1_hold", 32'(rsp1_valid), 32'd1);
      check("t4_data_hold", rsp_data, 32'hA5AA_0F01);
      check("t4_req0_blocked", 32'(req0_ready), 32'd0);
      tick();
      @(negedge clock);
    end
    tick();
    rsp1_ready = 1'b1;
    wait_accept(0);
    req0_valid = 1'b0;
    wait_rsp(0);
    tick();
    tick();
    @(negedge clock);
    check("t4_ops_done", 32'(ops_done), 32'd6);
    tick();

    // Boundary operands pass through unchanged
    req0_in = 32'hFFFF_FFFF; req0_shift = 5'd31; req0_op = 3'b111;
    req0_valid = 1'b1;
    wait_accept(0);
    req0_valid = 1'b0;
    @(negedge clock);
    check("t5_alu_in_max", alu_in, 32'hFFFF_FFFF);
    check("t5_alu_shift_31", 32'(alu_shift), 32'd31);
    check("t5_alu_op_7", 32'(alu_op), 32'd7);
    wait_rsp(0);
    tick();
    tick();
    req1_in = 32'h1234_5678; req1_shift = 5'd0; req1_op = 3'd0;
    req1_valid = 1'b1;
    wait_accept(1);
    req1_valid = 1'b0;
    @(negedge clock);
    check("t5_alu_shift_0", 32'(alu_shift), 32'd0);
    check("t5_alu_in", alu_in, 32'h1234_5678);
    wait_rsp(1);
    tick();
    tick();

    // Reset asserted during WAIT aborts the transaction
    req0_in = 32'h0000_0005; req0_shift = 5'd1; req0_op = 3'd0;
    req0_valid = 1'b1;
    wait_accept(0);
    req0_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rsp_data", rsp_data, 32'd0);
    check("t6_alu_in", alu_in, 32'd0);
    check("t6_alu_enable", 32'(alu_enable), 32'd0);
    check("t6_ops_done", 32'(ops_done), 32'd0);
    check("t6_rsp0_valid", 32'(rsp0_valid), 32'd0);
    @(negedge clock);
    #1 reset = 1'b0;
    tick();
    req1_in = 32'h0000_0100; req1_shift = 5'd2; req1_op = 3'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clock);
    check("t6_tie_req0", 32'(req0_ready), 32'd1);
    check("t6_tie_req1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(0);
    tick();
    tick();

    // ops_done wraps from 16'hFFFF to 0
    force dut.ops_done = 16'hFFFF;
    force_ops = 1'b1;
    #1 release dut.ops_done;
    req1_valid = 1'b1;
    wait_accept(1);
    req1_valid = 1'b0;
    wait_rsp(1);
    check("t7_ops_max", 32'(ops_done), 32'h0000_FFFF);
    tick();
    @(negedge clock);
    check("t7_ops_wrap", 32'(ops_done), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
